// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: cycle-by-cycle arbitration of the single-port character RAM, VGA fetches first, CPU in idle slots.
// Define CHAR_ARB_BLANK_ONLY_EN to restrict CPU grants to cycles where vga_blank is high.
module char_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_address,
    input  logic              vga_blank,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              mode
);
    typedef enum logic [1:0] {IDLE, VGA, CPU} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU} tag_t;

`ifdef CHAR_ARB_BLANK_ONLY_EN
    localparam bit BLANK_ONLY = 1'b1;
`else
    localparam bit BLANK_ONLY = 1'b0;
`endif

    state_t            state, state_nx;
    tag_t              tag0, tag1, tag_nx;
    logic              vga_pend, cpu_pend, cpu_busy, cpu_go, blank_ok;
    logic              grant_vga, grant_cpu, grant_wr;
    logic [ADDR_W-1:0] vga_addr_q;

    assign blank_ok = !BLANK_ONLY || vga_blank;
    assign mode     = state == CPU;

    // cpu_pend is the CPU request sampled one edge earlier, so a VGA request
    // arriving on the same edge always wins the first slot.
    always_comb begin
        cpu_go    = cpu_pend && !cpu_busy && !cpu_ack && blank_ok;
        state_nx  = vga_pend ? VGA : cpu_go ? CPU : IDLE;
        grant_vga = state_nx == VGA;
        grant_cpu = state_nx == CPU;
        grant_wr  = grant_cpu && cpu_we;
        tag_nx    = grant_vga ? TAG_VGA : (grant_cpu && !cpu_we) ? TAG_CPU : TAG_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tag0        <= TAG_NONE;
            tag1        <= TAG_NONE;
            vga_pend    <= 1'b0;
            vga_addr_q  <= '0;
            cpu_pend    <= 1'b0;
            cpu_busy    <= 1'b0;
            ram_address <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
            vga_data    <= '0;
            vga_valid   <= 1'b0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
        end else begin
            state    <= state_nx;
            tag0     <= tag_nx;
            tag1     <= tag0;
            cpu_pend <= cpu_req && !cpu_ack;
            if (vga_req) begin
                vga_pend   <= 1'b1;
                vga_addr_q <= vga_address;
            end else if (grant_vga) begin
                vga_pend <= 1'b0;
            end
            if (grant_vga) begin
                ram_address <= vga_addr_q;
            end else if (grant_cpu) begin
                ram_address <= cpu_address;
                ram_wdata   <= cpu_wdata;
            end
            ram_we    <= grant_wr;
            vga_valid <= tag1 == TAG_VGA;
            if (tag1 == TAG_VGA) vga_data <= ram_rdata;
            if (tag1 == TAG_CPU) cpu_rdata <= ram_rdata;
            cpu_ack  <= grant_wr || tag1 == TAG_CPU;
            cpu_busy <= (grant_cpu && !cpu_we) ? 1'b1 : (tag1 == TAG_CPU) ? 1'b0 : cpu_busy;
        end
    end
endmodule
